bram_port_arbiter: RTL
======================

Name: bram_port_arbiter

Overview:
- Shares one wide BRAM port, 128-bit by default, between two requesters, e.g. a PL engine and a PS-side BRAM controller.
- The port drives the column-split 8x16-bit BRAM bank.
- Arbitration is round-robin, one command issued per cycle, with registered BRAM outputs.
- Each read tracks the fixed BRAM read latency and routes read data back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 40, byte address width forwarded to the BRAM port.
- DATA_WIDTH, 128, data width; byte-enable width is DATA_WIDTH/8.
- RD_LATENCY, 2, BRAM cycles from sampled bram_en to valid bram_dout; legal range 1..4.

Ports:
- clk  in  1  single clock for all logic and the BRAM port.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_we  in  DATA_WIDTH/8  byte write enables; all-zero means read.
- req0_addr  in  ADDR_WIDTH  command address.
- req0_wdata  in  DATA_WIDTH  write data.
- rsp0_valid  out  1  read data valid for requester 0.
- rsp0_rdata  out  DATA_WIDTH  read data for requester 0.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1.
- bram_en  out  1  BRAM enable.
- bram_we  out  DATA_WIDTH/8  BRAM byte write enables.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_din  out  DATA_WIDTH  BRAM write data.
- bram_dout  in  DATA_WIDTH  BRAM read data.

Behaviour:
- Reset (rst_n low, async):
  - bram_en=0, bram_we=0, bram_addr=0, bram_din=0, rsp0_valid=0, rsp1_valid=0.
  - Read pipeline cleared.
  - Round-robin pointer last_grant=1, so requester 0 has priority first.
  - req0_ready=req1_ready=0 while rst_n low.
- Grant (combinational; ready may depend on valid, valid must not depend on ready):
  - Only one valid: that requester's ready=1.
  - Both valid: grant goes to the requester != last_grant.
  - Neither valid: both ready=0.
  - At most one ready high per cycle.
- Accept:
  - A command is accepted on valid&ready.
  - last_grant updates to the accepted id only on acceptance; it holds otherwise.
  - Worst-case wait for a continuously-valid requester: 1 cycle.
- Issue:
  - On the accept edge, bram_en=1 and bram_we/addr/din are registered from the winner.
  - Cycle with no accept: bram_en=0, bram_we=0; addr and din hold their last value.
- Read tracking:
  - Read = accepted command with we==0.
  - A shift register of depth RD_LATENCY+1 carries {valid, id}; a write inserts valid=0.
  - When the tail entry is valid, rsp<id>_valid=1 for exactly one cycle and rsp<id>_rdata=bram_dout.
  - Non-addressed rsp_rdata is driven to 0.
  - Latency: read accepted in cycle C gives rsp valid in cycle C+1+RD_LATENCY.
  - Responses return strictly in issue order; there is no response backpressure (requesters always accept).
  - Back-to-back reads sustain one response per cycle.
- Writes: no response generated; a write followed by a read to the same address returns the new data (BRAM in-order, read-first/write-first not relevant across cycles).
- Simultaneous events: accept and response in the same cycle are independent. Both rsp valids are never high together.
- Reset mid-operation: in-flight reads are dropped and never answered; the BRAM port is idle the cycle after reset deasserts.

Decomposition:
- Package bram_arb_pkg:
  - localparam RD_LATENCY_MAX=4.
  - typedef req_id_t (1 bit).
  - typedef struct rd_tag_t {logic valid; req_id_t id;}.
- Sub-module bram_rd_tracker: tag shift register plus response demux, parameterised by RD_LATENCY.
- The arbiter/issue logic stays in the top module.

Test Plan:
- Single read: req0 read addr=0x40 in cycle 0, BRAM model returns 0xA5..A5 -> bram_en=1, bram_addr=0x40 in cycle 1; rsp0_valid=1 with rdata=0xA5..A5 in cycle 3; rsp1_valid stays 0.
- Contention: both valid continuously with reads after reset -> grants alternate 0,1,0,1; responses alternate on rsp0/rsp1 at 1 per cycle from cycle 3.
- Write then read: req1 write we=0xFFFF data=0x1234.. addr=0x80, next cycle req1 read 0x80 -> rsp1_rdata=0x1234.. three cycles after the read accept; no response for the write.
- Partial write: we=0x0003 -> bram_we=0x0003 for one cycle only, then 0.
- Reset mid-flight: assert rst_n=0 one cycle after accepting two reads -> all outputs 0 asynchronously; no rsp_valid after release; first post-reset contention grants req0.
- RD_LATENCY=1 and 4 builds: single read -> rsp_valid in cycle 2 and cycle 5 respectively.

Source files
------------

// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and constants for the two-requester BRAM port arbiter.
package bram_arb_pkg;

    // Deepest read latency the tag pipeline is built for.
    localparam int RD_LATENCY_MAX = 4;

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    // One in-flight read slot: valid marks a read, id names its requester.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, id: REQ0};

    // Requester that should win a contended cycle, given the last winner.
    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side command/response channel of the BRAM port arbiter.
// The requester drives it through "master"; the arbiter serves it through "slave".
interface bram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 128
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [BE_WIDTH-1:0]   we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/bram_port_arbiter_rd_tracker.sv
// Read tracker: carries a {valid, id} tag alongside each issued command for
// the BRAM read latency, then steers bram_dout to the requester that asked.
module bram_rd_tracker
    import bram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  rd_tag_t               tag_i,
    input  logic [DATA_WIDTH-1:0] bram_dout_i,
    output logic                  rsp0_valid_o,
    output logic [DATA_WIDTH-1:0] rsp0_rdata_o,
    output logic                  rsp1_valid_o,
    output logic [DATA_WIDTH-1:0] rsp1_rdata_o
);
    // Out-of-range latencies are pinned to the supported 1..RD_LATENCY_MAX window.
    localparam int LAT_EFF = (RD_LATENCY < 1) ? 1 :
                             ((RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY);
    // One stage for the issue register plus one per BRAM latency cycle.
    localparam int DEPTH   = LAT_EFF + 1;

    rd_tag_t tag_q [DEPTH];
    rd_tag_t tag_d [DEPTH];
    rd_tag_t tail_s;

    // Shift: the new tag enters stage 0, every other stage moves one toward the tail.
    always_comb begin
        tag_d[0] = tag_i;
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Tag pipeline registers; reset drops every in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= RD_TAG_IDLE;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign tail_s = tag_q[DEPTH-1];

    // Response demux: only the addressed requester sees data, the other sees zero.
    always_comb begin
        rsp0_valid_o = 1'b0;
        rsp0_rdata_o = {DATA_WIDTH{1'b0}};
        rsp1_valid_o = 1'b0;
        rsp1_rdata_o = {DATA_WIDTH{1'b0}};
        if (tail_s.valid) begin
            if (tail_s.id == REQ0) begin
                rsp0_valid_o = 1'b1;
                rsp0_rdata_o = bram_dout_i;
            end else begin
                rsp1_valid_o = 1'b1;
                rsp1_rdata_o = bram_dout_i;
            end
        end else begin
            rsp0_valid_o = 1'b0;
            rsp1_valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one wide BRAM port between two requesters.
// One command issues per cycle through registered BRAM outputs; reads are
// answered on the requester's response channel after the BRAM latency.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 128,
    parameter int RD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bram_port_arbiter_if.slave      req0,
    bram_port_arbiter_if.slave      req1,
    output logic                    bram_en,
    output logic [DATA_WIDTH/8-1:0] bram_we,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH-1:0]   bram_din,
    input  logic [DATA_WIDTH-1:0]   bram_dout
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  grant0_s;
    logic                  grant1_s;
    logic                  accept_s;
    req_id_t               win_id_s;
    logic [BE_WIDTH-1:0]   win_we_s;
    logic [ADDR_WIDTH-1:0] win_addr_s;
    logic [DATA_WIDTH-1:0] win_wdata_s;
    rd_tag_t               rd_tag_s;

    req_id_t               last_grant_q, last_grant_d;
    logic                  bram_en_q,    bram_en_d;
    logic [BE_WIDTH-1:0]   bram_we_q,    bram_we_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q,  bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_din_q,   bram_din_d;

    // Grant: a lone requester wins; on contention the one not granted last wins.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst_n == 1'b0) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req0.valid && req1.valid) begin
            if (other_req(last_grant_q) == REQ0) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (req0.valid) begin
            grant0_s = 1'b1;
        end else if (req1.valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign req0.ready = grant0_s;
    assign req1.ready = grant1_s;
    assign accept_s   = grant0_s | grant1_s;
    assign win_id_s   = grant1_s ? REQ1 : REQ0;

    // Winner mux: pick the command fields of the granted requester.
    always_comb begin
        win_we_s    = req0.we;
        win_addr_s  = req0.addr;
        win_wdata_s = req0.wdata;
        if (win_id_s == REQ1) begin
            win_we_s    = req1.we;
            win_addr_s  = req1.addr;
            win_wdata_s = req1.wdata;
        end else begin
            win_we_s    = req0.we;
            win_addr_s  = req0.addr;
            win_wdata_s = req0.wdata;
        end
    end

    // Issue next-state: strobe the port on accept, otherwise idle it while
    // address and data hold so the BRAM pins do not toggle needlessly.
    always_comb begin
        last_grant_d = last_grant_q;
        bram_en_d    = 1'b0;
        bram_we_d    = {BE_WIDTH{1'b0}};
        bram_addr_d  = bram_addr_q;
        bram_din_d   = bram_din_q;
        rd_tag_s     = RD_TAG_IDLE;
        if (accept_s) begin
            last_grant_d   = win_id_s;
            bram_en_d      = 1'b1;
            bram_we_d      = win_we_s;
            bram_addr_d    = win_addr_s;
            bram_din_d     = win_wdata_s;
            rd_tag_s.valid = (win_we_s == {BE_WIDTH{1'b0}});
            rd_tag_s.id    = win_id_s;
        end else begin
            bram_en_d = 1'b0;
            bram_we_d = {BE_WIDTH{1'b0}};
        end
    end

    // Issue registers and round-robin pointer; requester 0 is favoured first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ1;
            bram_en_q    <= 1'b0;
            bram_we_q    <= {BE_WIDTH{1'b0}};
            bram_addr_q  <= {ADDR_WIDTH{1'b0}};
            bram_din_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            last_grant_q <= last_grant_d;
            bram_en_q    <= bram_en_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_din_q   <= bram_din_d;
        end
    end

    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;

    bram_rd_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .tag_i        (rd_tag_s),
        .bram_dout_i  (bram_dout),
        .rsp0_valid_o (req0.rsp_valid),
        .rsp0_rdata_o (req0.rsp_rdata),
        .rsp1_valid_o (req1.rsp_valid),
        .rsp1_rdata_o (req1.rsp_rdata)
    );

endmodule
